// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/scoreboard bus of the multi-port register file.
// The master modport belongs to the core (decode + writeback), and the slave
// modport belongs to the register file. AW is derived from NREG here so both
// sides agree on the address width.
interface regfile_mp_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
);
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [NRD*AW-1:0]   rs_addr;
   logic [NRD*XLEN-1:0] rs_data;
   logic [NRD-1:0]      rs_busy;
   logic                wb0_wren;
   logic [AW-1:0]       wb0_addr;
   logic [XLEN-1:0]     wb0_data;
   logic                wb1_wren;
   logic [AW-1:0]       wb1_addr;
   logic [XLEN-1:0]     wb1_data;
   logic                sb_set;
   logic [AW-1:0]       sb_addr;
   logic                sb_flush;

   modport master (
      output rs_addr, wb0_wren, wb0_addr, wb0_data,
             wb1_wren, wb1_addr, wb1_data, sb_set, sb_addr, sb_flush,
      input  rs_data, rs_busy
   );

   modport slave (
      input  rs_addr, wb0_wren, wb0_addr, wb0_data,
             wb1_wren, wb1_addr, wb1_data, sb_set, sb_addr, sb_flush,
      output rs_data, rs_busy
   );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NRD combinational read ports, two write ports (wb1 wins a
// collision) and a per-register pending-write scoreboard for RAW detection.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle write-through
// forwarding from the write ports to the read ports.
module regfile_mp #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int ZERO = 1
) (
   input logic          clk,
   input logic          rst,
   regfile_mp_if.slave  bus
);
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [AW:0] NREG_W = NREG[AW:0];

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;

   // Address selects an implemented register (matters for non-power-of-2 NREG).
   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < NREG_W;
   endfunction

   // Address may be written/set: implemented and not the hardwired zero register.
   function automatic logic writable(input logic [AW-1:0] a);
      return in_range(a) && !((ZERO != 0) && (a == '0));
   endfunction

   logic wb0_ok, wb1_ok, sb_ok;
   assign wb0_ok = bus.wb0_wren && writable(bus.wb0_addr);
   assign wb1_ok = bus.wb1_wren && writable(bus.wb1_addr);
   assign sb_ok  = bus.sb_set   && writable(bus.sb_addr);

   // Next scoreboard state: flush, then write-clears, then set (newest producer wins).
   always_comb begin
      // NOTE: default assignment first so no path through this block infers a latch.
      busy_nxt = busy;
      if (bus.sb_flush) busy_nxt = '0;
      if (wb0_ok) busy_nxt[bus.wb0_addr] = 1'b0;
      if (wb1_ok) busy_nxt[bus.wb1_addr] = 1'b0;
      if (sb_ok)  busy_nxt[bus.sb_addr]  = 1'b1;
   end

   // Register array and scoreboard update; reset overrides every other request.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the array is built from plain flops, so resetting it is legal here;
         // a RAM macro could not be cleared this way.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         // NOTE: non-blocking so every flop updates from pre-edge values; the wb1
         // assignment comes last so it wins a same-address collision.
         if (wb0_ok) regs[bus.wb0_addr] <= bus.wb0_data;
         if (wb1_ok) regs[bus.wb1_addr] <= bus.wb1_data;
         busy <= busy_nxt;
      end
   end

   // Combinational read ports, with optional forwarding of in-flight writes.
   always_comb begin
      logic [AW-1:0] a;
      bus.rs_data = '0;
      bus.rs_busy = '0;
      for (int k = 0; k < NRD; k++) begin
         a = bus.rs_addr[k*AW +: AW];
         if (writable(a)) begin
            bus.rs_data[k*XLEN +: XLEN] = regs[a];
            bus.rs_busy[k]              = busy[a];
`ifdef REGFILE_BYPASS_EN
            if (wb0_ok && bus.wb0_addr == a) begin
               bus.rs_data[k*XLEN +: XLEN] = bus.wb0_data;
               bus.rs_busy[k]              = 1'b0;
            end
            if (wb1_ok && bus.wb1_addr == a) begin
               bus.rs_data[k*XLEN +: XLEN] = bus.wb1_data;
               bus.rs_busy[k]              = 1'b0;
            end
`endif
         end
      end
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp. Instance u_dut uses default
// parameters; u_dut_b uses NREG=24, NRD=4 for out-of-range address handling.
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN.
module tb_regfile_mp;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();
   regfile_mp_if #(.XLEN(32), .NREG(24), .NRD(4)) bus_b ();

   regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO(1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   regfile_mp #(.XLEN(32), .NREG(24), .NRD(4), .ZERO(1)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wb0_wren = 0; bus.wb0_addr = '0; bus.wb0_data = '0;
      bus.wb1_wren = 0; bus.wb1_addr = '0; bus.wb1_data = '0;
      bus.sb_set = 0; bus.sb_addr = '0; bus.sb_flush = 0;
      bus_b.wb0_wren = 0; bus_b.wb0_addr = '0; bus_b.wb0_data = '0;
      bus_b.wb1_wren = 0; bus_b.wb1_addr = '0; bus_b.wb1_data = '0;
      bus_b.sb_set = 0; bus_b.sb_addr = '0; bus_b.sb_flush = 0;
   endtask

   task automatic rd(input int k, input logic [4:0] a);
      bus.rs_addr[k*5 +: 5] = a;
   endtask

   function automatic logic [31:0] dat(input int k);
      return bus.rs_data[k*32 +: 32];
   endfunction

   function automatic logic [31:0] bsy(input int k);
      return {31'b0, bus.rs_busy[k]};
   endfunction

   logic [31:0] exp_same;

   initial begin
      idle();
      bus.rs_addr = '0;
      bus_b.rs_addr = '0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      rd(0, 5'd5); rd(1, 5'd31);
      #1;
      check("reset_x5_data", dat(0), 32'h0);
      check("reset_x31_data", dat(1), 32'h0);
      check("reset_busy", {30'b0, bus.rs_busy}, 32'h0);

      // Test 1: write x5 and mark it busy, then reset clears both.
      bus.wb0_wren = 1; bus.wb0_addr = 5'd5; bus.wb0_data = 32'hDEAD;
      bus.sb_set = 1; bus.sb_addr = 5'd5;
      tick(); idle(); #1;
      check("x5_written", dat(0), 32'hDEAD);
      check("x5_busy_set", bsy(0), 32'h1);
      rst = 1'b1;
      bus.wb0_wren = 1; bus.wb0_addr = 5'd5; bus.wb0_data = 32'h1234;
      tick(); rst = 1'b0; idle(); #1;
      check("rst_x5_data", dat(0), 32'h0);
      check("rst_x5_busy", bsy(0), 32'h0);

      // Test 2: x0 is hardwired zero, never busy.
      bus.wb0_wren = 1; bus.wb0_addr = 5'd0; bus.wb0_data = 32'hFFFF_FFFF;
      bus.sb_set = 1; bus.sb_addr = 5'd0;
      rd(0, 5'd0);
      tick(); idle(); #1;
      check("x0_data", dat(0), 32'h0);
      check("x0_busy", bsy(0), 32'h0);

      // Test 3: write collision, wb1 wins.
      bus.wb0_wren = 1; bus.wb0_addr = 5'd7; bus.wb0_data = 32'h1111;
      bus.wb1_wren = 1; bus.wb1_addr = 5'd7; bus.wb1_data = 32'h2222;
      rd(1, 5'd7);
      tick(); idle(); #1;
      check("collision_x7", dat(1), 32'h2222);

      // Test 4: scoreboard set, set-beats-clear, flush.
      bus.sb_set = 1; bus.sb_addr = 5'd3;
      rd(0, 5'd3);
      tick(); idle(); #1;
      check("sb_x3_busy", bsy(0), 32'h1);
      bus.wb1_wren = 1; bus.wb1_addr = 5'd3; bus.wb1_data = 32'h42;
      bus.sb_set = 1; bus.sb_addr = 5'd3;
      tick(); idle(); #1;
      check("sb_set_wins_busy", bsy(0), 32'h1);
      check("sb_set_wins_data", dat(0), 32'h42);
      bus.sb_flush = 1;
      tick(); idle(); #1;
      check("flush_busy", bsy(0), 32'h0);
      check("flush_keeps_data", dat(0), 32'h42);

      // Write clears a pending bit.
      bus.sb_set = 1; bus.sb_addr = 5'd10;
      rd(1, 5'd10);
      tick(); idle(); #1;
      check("x10_busy", bsy(1), 32'h1);
      bus.wb0_wren = 1; bus.wb0_addr = 5'd10; bus.wb0_data = 32'h5;
      tick(); idle(); #1;
      check("x10_cleared", bsy(1), 32'h0);
      check("x10_data", dat(1), 32'h5);

      // Flush together with set: set wins for its address, others cleared.
      bus.sb_set = 1; bus.sb_addr = 5'd11;
      tick(); idle();
      bus.sb_flush = 1; bus.sb_set = 1; bus.sb_addr = 5'd12;
      rd(0, 5'd11); rd(1, 5'd12);
      tick(); idle(); #1;
      check("flushset_x11", bsy(0), 32'h0);
      check("flushset_x12", bsy(1), 32'h1);

      // Test 5: same-cycle read of a register being written.
      rd(0, 5'd9); rd(1, 5'd9);
      bus.wb0_wren = 1; bus.wb0_addr = 5'd9; bus.wb0_data = 32'hABCD;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'hABCD;
`else
      exp_same = 32'h0;
`endif
      check("same_cycle_x9", dat(0), exp_same);
      check("same_cycle_x9_busy", bsy(0), 32'h0);
      tick(); idle(); #1;
      check("next_cycle_x9", dat(0), 32'hABCD);
      bus.wb0_wren = 1; bus.wb0_addr = 5'd9; bus.wb0_data = 32'h1;
      bus.wb1_wren = 1; bus.wb1_addr = 5'd9; bus.wb1_data = 32'h2;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'h2;
`else
      exp_same = 32'hABCD;
`endif
      check("same_cycle_wb1_over_wb0", dat(1), exp_same);
      tick(); idle(); #1;
      check("next_cycle_x9_wb1", dat(1), 32'h2);

      // Test 6: NREG=24, NRD=4 - out-of-range writes/sets ignored, reads 0.
      bus_b.wb0_wren = 1; bus_b.wb0_addr = 5'd30; bus_b.wb0_data = 32'hCAFE;
      bus_b.wb1_wren = 1; bus_b.wb1_addr = 5'd23; bus_b.wb1_data = 32'h77;
      bus_b.sb_set = 1; bus_b.sb_addr = 5'd30;
      tick(); idle();
      bus_b.rs_addr = {5'd30, 5'd30, 5'd30, 5'd23};
      #1;
      check("b_x23_data", bus_b.rs_data[31:0], 32'h77);
      for (int k = 1; k < 4; k++) begin
         check($sformatf("b_addr30_port%0d", k), bus_b.rs_data[k*32 +: 32], 32'h0);
      end
      check("b_addr30_busy", {28'b0, bus_b.rs_busy}, 32'h0);
      bus_b.rs_addr = {5'd6, 5'd6, 5'd6, 5'd6};
      #1;
      check("b_alias_x6", bus_b.rs_data[127:96], 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
